// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A interrupt-acknowledge path.
package pic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      ACK1,
      WAIT2,
      ACK2
   } ack_state_t;

   localparam logic [2:0] SPURIOUS_IR    = 3'd7;
   localparam logic       SYNC_RESET_VAL = 1'b1;

endpackage

// File: rtl/inta_edge_sync.sv
// Synchronises the asynchronous INTA_n pin into clk and flags its edges.
// Edge flags appear SYNC_STAGES cycles after a pin edge, so the FSM acts SYNC_STAGES+1 edges after it.
module inta_edge_sync
   import pic_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic INTA_n,
   output logic fallDet,
   output logic riseDet
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   cur;

   assign cur = sync_q[SYNC_STAGES-1];

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= {SYNC_STAGES{SYNC_RESET_VAL}};
         prev_q <= SYNC_RESET_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], INTA_n};
         prev_q <= cur;
      end
   end

   assign fallDet = prev_q & ~cur;
   assign riseDet = ~prev_q & cur;

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// INTA handshake controller: raises INT, follows the two-pulse 8086 acknowledge,
// and strobes the in-service register while holding the IRR frozen.
module interrupt_ack_sequencer
   import pic_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int ACK_TIMEOUT = 255,
   parameter int TIMER_W     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       initDone,
   input  logic       highestValid,
   input  logic [2:0] highestIndex,
   input  logic       INTA_n,
   output logic       INT,
   output logic       freezeIrr,
   output logic       readPriority,
   output logic       sendVector,
   output logic       secondACK,
   output logic [2:0] toSet,
   output logic       spurious
);

   localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(ACK_TIMEOUT);

   ack_state_t         state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [2:0]         to_set_q, to_set_d;
   logic               spur_q, spur_d;
   logic               rp_q, rp_d;
   logic               sv_q, sv_d;
   logic               sa_q, sa_d;
   logic               fall_det;
   logic               rise_det;

   inta_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .reset  (reset),
      .INTA_n (INTA_n),
      .fallDet(fall_det),
      .riseDet(rise_det)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         to_set_q <= SPURIOUS_IR;
         spur_q   <= 1'b0;
         rp_q     <= 1'b0;
         sv_q     <= 1'b0;
         sa_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         to_set_q <= to_set_d;
         spur_q   <= spur_d;
         rp_q     <= rp_d;
         sv_q     <= sv_d;
         sa_q     <= sa_d;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      to_set_d = to_set_q;
      spur_d   = spur_q;
      rp_d     = 1'b0;
      sv_d     = 1'b0;
      sa_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            timer_d = '0;
            if (initDone && highestValid) state_d = REQ;
         end
         REQ: begin
            // A fall on the same edge as a valid drop still wins and yields the IR7 default.
            if (fall_det) begin
               state_d  = ACK1;
               to_set_d = highestValid ? highestIndex : SPURIOUS_IR;
               spur_d   = ~highestValid;
               rp_d     = 1'b1;
            end else if (!highestValid || !initDone) begin
               state_d = IDLE;
            end
         end
         ACK1: begin
            if (rise_det) begin
               state_d = WAIT2;
               timer_d = '0;
            end
         end
         WAIT2: begin
            timer_d = timer_q + TIMER_W'(1);
            if (fall_det) begin
               state_d = ACK2;
               sv_d    = 1'b1;
            end else if (timer_d == TIMEOUT_VAL) begin
               state_d = IDLE;
            end
         end
         ACK2: begin
            if (rise_det) begin
               state_d = IDLE;
               sa_d    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // INT and freezeIrr follow the state directly so an async reset clears them at once.
   assign INT          = (state_q == REQ);
   assign freezeIrr    = (state_q == ACK1) || (state_q == WAIT2) || (state_q == ACK2);
   assign readPriority = rp_q;
   assign sendVector   = sv_q;
   assign secondACK    = sa_q;
   assign toSet        = to_set_q;
   assign spurious     = spur_q;

endmodule
